// File: rtl/relu_maxpool_if.sv
// relu_maxpool_if: conv sample stream into, and pooled window stream out of, relu_maxpool.
// The producer/consumer side uses master; the pooling stage uses slave.
interface relu_maxpool_if #(
   parameter int CH_WIDTH = 21
);
   logic                    start;
   logic                    de_in;
   logic [3*CH_WIDTH-1:0]   result_in;
   logic [3*CH_WIDTH-1:0]   pool_out;
   logic                    de_pool;
   logic [4:0]              pool_col;
   logic [4:0]              pool_row;
   logic                    frame_done;
   modport master (
      output start, de_in, result_in,
      input  pool_out, de_pool, pool_col, pool_row, frame_done
   );
   modport slave (
      input  start, de_in, result_in,
      output pool_out, de_pool, pool_col, pool_row, frame_done
   );
endinterface

// File: rtl/relu_maxpool.sv
// relu_maxpool: per-channel ReLU then 2x2/stride-2 max pooling over a 3-channel row stream.
// Define RELU_EN to clamp negative sums to zero; otherwise pooling is a signed max of raw sums.
module relu_maxpool #(
   parameter int CH_WIDTH  = 21,
   parameter int IN_WIDTH  = 26,
   parameter int IN_HEIGHT = 26
) (
   input logic           clk,
   input logic           RESET,
   relu_maxpool_if.slave bus
);
   localparam int HW = IN_WIDTH / 2;
   localparam int AW = HW > 1 ? $clog2(HW) : 1;
   localparam int CW = $clog2(IN_WIDTH + 1);
   localparam int RW = IN_HEIGHT > 1 ? $clog2(IN_HEIGHT) : 1;
   logic [CW-1:0]               col_cnt;
   logic [RW-1:0]               row_cnt;
   logic                        de_d;
   logic signed [CH_WIDTH-1:0]  h_reg [3];
   logic [3*CH_WIDTH-1:0]       lb [HW];
   logic signed [CH_WIDTH-1:0]  x [3];
   logic signed [CH_WIDTH-1:0]  v [3];
   logic signed [CH_WIDTH-1:0]  h [3];
   logic signed [CH_WIDTH-1:0]  l [3];
   logic signed [CH_WIDTH-1:0]  p [3];
   logic [3*CH_WIDTH-1:0]       h_word;
   logic [3*CH_WIDTH-1:0]       p_word;
   logic [AW-1:0]               idx;
   logic                        clr;
   logic                        take;
   logic                        row_end;
   logic                        last_row;
   logic                        emit;
   assign clr      = !RESET || !bus.start;
   assign take     = bus.de_in && col_cnt < CW'(IN_WIDTH);
   assign row_end  = de_d && !bus.de_in;
   assign last_row = row_cnt == RW'(IN_HEIGHT - 1);
   assign emit     = take && col_cnt[0] && row_cnt[0];
   assign idx      = AW'(col_cnt >> 1);
   always_comb begin
      h_word = '0;
      p_word = '0;
      for (int c = 0; c < 3; c++) begin
         x[c] = bus.result_in[(3-c)*CH_WIDTH-1 -: CH_WIDTH];
`ifdef RELU_EN
         v[c] = x[c][CH_WIDTH-1] ? '0 : x[c];
`else
         v[c] = x[c];
`endif
         h[c] = v[c] > h_reg[c] ? v[c] : h_reg[c];
         l[c] = lb[idx][(3-c)*CH_WIDTH-1 -: CH_WIDTH];
         p[c] = h[c] > l[c] ? h[c] : l[c];
         h_word[(3-c)*CH_WIDTH-1 -: CH_WIDTH] = h[c];
         p_word[(3-c)*CH_WIDTH-1 -: CH_WIDTH] = p[c];
      end
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         col_cnt        <= '0;
         row_cnt        <= '0;
         de_d           <= 1'b0;
         bus.pool_out   <= '0;
         bus.de_pool    <= 1'b0;
         bus.pool_col   <= '0;
         bus.pool_row   <= '0;
         bus.frame_done <= 1'b0;
         for (int c = 0; c < 3; c++) h_reg[c] <= '0;
      end else begin
         de_d           <= bus.de_in;
         bus.de_pool    <= emit;
         bus.frame_done <= row_end && last_row;
         // Saturate so an over-long row cannot wrap back into valid columns.
         if (bus.de_in)
            col_cnt <= col_cnt == CW'(IN_WIDTH) ? col_cnt : col_cnt + 1'b1;
         else if (row_end) begin
            col_cnt <= '0;
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
         end
         if (take && !col_cnt[0])
            for (int c = 0; c < 3; c++) h_reg[c] <= v[c];
         if (emit) begin
            bus.pool_out <= p_word;
            bus.pool_col <= 5'(col_cnt >> 1);
            bus.pool_row <= 5'(row_cnt >> 1);
         end
      end
   end
   always_ff @(posedge clk)
      if (take && col_cnt[0] && !row_cnt[0]) lb[idx] <= h_word;
endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: directed checks of relu_maxpool on a 26x26 instance and a 5x3 odd-geometry instance.
module tb_relu_maxpool;
   logic clk;
   logic RESET;
   int   n_chk;
   int   n_pass;
   int   fd0;
   int   fd1;
   int   b2b;
   logic prev0;
   logic prev1;
   logic [72:0] q0[$];
   logic [72:0] q1[$];
   relu_maxpool_if #(.CH_WIDTH(21)) b0();
   relu_maxpool_if #(.CH_WIDTH(21)) b1();
   relu_maxpool #(.CH_WIDTH(21), .IN_WIDTH(26), .IN_HEIGHT(26)) u0 (.clk(clk), .RESET(RESET), .bus(b0));
   relu_maxpool #(.CH_WIDTH(21), .IN_WIDTH(5), .IN_HEIGHT(3)) u1 (.clk(clk), .RESET(RESET), .bus(b1));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (b0.de_pool) q0.push_back({b0.pool_row, b0.pool_col, b0.pool_out});
      if (b1.de_pool) q1.push_back({b1.pool_row, b1.pool_col, b1.pool_out});
      if ((b0.de_pool && prev0) || (b1.de_pool && prev1)) b2b++;
      prev0 = b0.de_pool;
      prev1 = b1.de_pool;
      if (b0.frame_done) fd0++;
      if (b1.frame_done) fd1++;
   end
   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drv(input int sel, input logic de, input logic [62:0] d);
      if (sel == 0) begin
         b0.de_in = de;
         b0.result_in = d;
      end else begin
         b1.de_in = de;
         b1.result_in = d;
      end
      tick();
   endtask
   function automatic logic [62:0] pix(input int r, input int c, input int mode);
      int v;
      logic [20:0] a;
      logic [20:0] b;
      logic [20:0] d;
      v = r * 26 + c;
      a = 21'(mode != 0 ? 675 - v : v);
      b = 21'(v);
      d = 21'(mode != 0 ? -v : v);
      return {a, b, d};
   endfunction
   // Reference window: ReLU (when enabled) then signed max over the four pixels, per channel.
   function automatic logic [62:0] ref_win(input int wr, input int wc, input int mode);
      logic [62:0] res;
      logic [62:0] w;
      logic signed [20:0] best;
      logic signed [20:0] s;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         best = 21'sh100000;
         for (int k = 0; k < 4; k++) begin
            w = pix(2 * wr + k / 2, 2 * wc + k % 2, mode);
            s = w[62-21*ch -: 21];
`ifdef RELU_EN
            if (s < 0) s = '0;
`endif
            if (s > best) best = s;
         end
         res[62-21*ch -: 21] = best;
      end
      return res;
   endfunction
   task automatic restart0();
      b0.start = 1'b0;
      drv(0, 1'b0, '0);
      b0.start = 1'b1;
      q0.delete();
      fd0 = 0;
   endtask
   task automatic run_frame(input int mode);
      for (int r = 0; r < 26; r++) begin
         for (int c = 0; c < 26; c++) drv(0, 1'b1, pix(r, c, mode));
         drv(0, 1'b0, '0);
      end
      drv(0, 1'b0, '0);
      drv(0, 1'b0, '0);
   endtask
   task automatic check_frame(input string tag, input int mode);
      logic [72:0] got;
      check({tag, "_count"}, 80'(q0.size()), 80'd169);
      check({tag, "_frame_done"}, 80'(fd0), 80'd1);
      for (int k = 0; k < 169; k++) begin
         got = k < q0.size() ? q0[k] : '1;
         check({tag, "_win"}, 80'(got), 80'({5'(k / 13), 5'(k % 13), ref_win(k / 13, k % 13, mode)}));
      end
   endtask
   task automatic window(input string tag, input logic [62:0] a, input logic [62:0] b,
                         input logic [62:0] c, input logic [62:0] d, input logic [62:0] exp);
      restart0();
      drv(0, 1'b1, a);
      drv(0, 1'b1, b);
      drv(0, 1'b0, '0);
      drv(0, 1'b1, c);
      drv(0, 1'b1, d);
      check({tag, "_de_pool"}, 80'(b0.de_pool), 80'd1);
      check({tag, "_pool_out"}, 80'(b0.pool_out), 80'(exp));
      check({tag, "_pos"}, 80'({b0.pool_row, b0.pool_col}), 80'd0);
      drv(0, 1'b0, '0);
   endtask
   initial begin
      logic [20:0] t;
      n_chk = 0;
      n_pass = 0;
      fd0 = 0;
      fd1 = 0;
      b2b = 0;
      prev0 = 1'b0;
      prev1 = 1'b0;
      RESET = 1'b0;
      b0.start = 1'b0;
      b0.de_in = 1'b0;
      b0.result_in = '0;
      b1.start = 1'b0;
      b1.de_in = 1'b0;
      b1.result_in = '0;
      repeat (3) tick();
      check("rst_pool_out", 80'(b0.pool_out), 80'd0);
      check("rst_de_pool", 80'(b0.de_pool), 80'd0);
      check("rst_pool_col", 80'(b0.pool_col), 80'd0);
      check("rst_pool_row", 80'(b0.pool_row), 80'd0);
      check("rst_frame_done", 80'(b0.frame_done), 80'd0);
      RESET = 1'b1;
      b1.start = 1'b1;
      restart0();
      run_frame(0);
      check("ramp_first", 80'(q0.size() > 0 ? q0[0] : '1), 80'({10'd0, {3{21'd27}}}));
      check("ramp_last", 80'(q0.size() > 168 ? q0[168] : '1), 80'({5'd12, 5'd12, {3{21'd675}}}));
      check_frame("ramp", 0);
`ifdef RELU_EN
      window("neg", {21'd1, 21'h1FFFFB, 21'd0}, {21'd2, 21'h1FFFFF, 21'd0},
             {21'd3, 21'h1FFFF9, 21'd0}, {21'd4, 21'h1FFFFD, 21'd0}, {21'd4, 21'd0, 21'd0});
`else
      window("neg", {21'd1, 21'h1FFFFB, 21'd0}, {21'd2, 21'h1FFFFF, 21'd0},
             {21'd3, 21'h1FFFF9, 21'd0}, {21'd4, 21'h1FFFFD, 21'd0}, {21'd4, 21'h1FFFFF, 21'd0});
`endif
      window("chan", {21'd1, 21'd8, 21'd0}, {21'd9, 21'd0, 21'd0},
             {21'd2, 21'd0, 21'd0}, {21'd3, 21'd0, 21'd4}, {21'd9, 21'd8, 21'd4});
      q1.delete();
      fd1 = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 5; c++) begin
            t = 21'(r * 5 + c);
            drv(1, 1'b1, {t, t, t});
         end
         drv(1, 1'b0, '0);
      end
      drv(1, 1'b0, '0);
      drv(1, 1'b0, '0);
      check("odd_count", 80'(q1.size()), 80'd2);
      check("odd_win0", 80'(q1.size() > 0 ? q1[0] : '1), 80'({10'd0, {3{21'd6}}}));
      check("odd_win1", 80'(q1.size() > 1 ? q1[1] : '1), 80'({5'd0, 5'd1, {3{21'd8}}}));
      check("odd_frame_done", 80'(fd1), 80'd1);
      restart0();
      for (int c = 0; c < 26; c++) drv(0, 1'b1, pix(0, c, 0));
      drv(0, 1'b0, '0);
      for (int c = 0; c < 7; c++) drv(0, 1'b1, pix(1, c, 0));
      RESET = 1'b0;
      drv(0, 1'b1, pix(1, 7, 0));
      check("abort_de_pool", 80'(b0.de_pool), 80'd0);
      check("abort_pool_out", 80'(b0.pool_out), 80'd0);
      check("abort_pos", 80'({b0.pool_row, b0.pool_col}), 80'd0);
      RESET = 1'b1;
      drv(0, 1'b0, '0);
      q0.delete();
      fd0 = 0;
      run_frame(0);
      check_frame("after_reset", 0);
      restart0();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 26; c++) drv(0, 1'b1, pix(r, c, 0));
         drv(0, 1'b0, '0);
      end
      for (int c = 0; c < 10; c++) drv(0, 1'b1, pix(4, c, 0));
      b0.start = 1'b0;
      drv(0, 1'b0, '0);
      check("stop_pool_out", 80'(b0.pool_out), 80'd0);
      check("stop_pos", 80'({b0.pool_row, b0.pool_col}), 80'd0);
      drv(0, 1'b0, '0);
      drv(0, 1'b0, '0);
      b0.start = 1'b1;
      q0.delete();
      fd0 = 0;
      run_frame(1);
      check("fresh_first", 80'(q0.size() > 0 ? q0[0] : '1),
`ifdef RELU_EN
            80'({10'd0, 21'd675, 21'd27, 21'd0}));
`else
            80'({10'd0, 21'd675, 21'd27, 21'd0}));
`endif
      check_frame("fresh", 1);
      check("no_back_to_back", 80'(b2b), 80'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Downstream stage of the 3×3 convolution layer. It consumes the conv stream of three packed signed 21-bit channel sums, qualified by a data-enable that is high once per output row. It applies ReLU per channel and 2×2 / stride-2 max pooling, and emits one pooled 3-channel word per 2×2 window with its own data-enable, plus window coordinates and a frame-done pulse. Row pairing uses an internal half-width line buffer, so no external RAM is needed.

## Interface
Parameters:
- CH_WIDTH, 21: width of one channel sum (signed two's complement).
- IN_WIDTH, 26: conv output pixels per row.
- IN_HEIGHT, 26: conv output rows per frame.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- RESET  in  1  synchronous, active-low reset (sampled on clk; 0 = reset).
- start  in  1  frame enable; low clears counters and line buffer valid state.
- de_in  in  1  input data-enable; high for each valid conv sample.
- result_in  in  3*CH_WIDTH  {ch0, ch1, ch2}; ch0 in the MSBs.
- pool_out  out  3*CH_WIDTH  pooled {ch0, ch1, ch2}, registered.
- de_pool  out  1  pool_out valid, single-cycle strobe per window.
- pool_col  out  5  window column index (0..IN_WIDTH/2-1), valid with de_pool.
- pool_row  out  5  window row index (0..IN_HEIGHT/2-1), valid with de_pool.
- frame_done  out  1  one-cycle pulse after the last row of a frame ends.

## Operation
- Counters:
  - col_cnt advances on each cycle with de_in=1.
  - Falling edge of de_in (registered de_in=1, de_in=0) ends a row: col_cnt←0 and row_cnt increments.
  - When row_cnt=IN_HEIGHT-1 and a row ends, row_cnt←0 and frame_done pulses.
- Samples with col_cnt ≥ IN_WIDTH are ignored. If IN_WIDTH is odd, the last column is dropped; if IN_HEIGHT is odd, the last row is dropped (it is processed but never emitted).
- Stage A, per channel: v = ReLU(x) = x<0 ? 0 : x, compared as signed values.
- Even col_cnt: hold v in h_reg[ch].
- Odd col_cnt: h = max(h_reg[ch], v).
  - Even row_cnt: write h to lb[col_cnt>>1][ch].
  - Odd row_cnt: p = max(lb[col_cnt>>1][ch], h). Register p into pool_out, assert de_pool, set pool_col=col_cnt>>1 and pool_row=row_cnt>>1.
- Line buffer: IN_WIDTH/2 entries × 3*CH_WIDTH, implemented as registers with no reset on the data.
- Ties resolve to either operand; the value is the same either way.
- de_in gaps inside a row are legal only if de_in stays high. Any low cycle ends the row.
- start=0 has reset-equivalent effect on the counters, h_reg and all outputs. Line buffer contents are don't-care.

## Timing
- Reset values: pool_out=0, de_pool=0, pool_col=0, pool_row=0, frame_done=0. Counters=0.
- Latency: de_pool and pool_out appear on the cycle after the clk edge that samples the odd-column, odd-row input (1 cycle). No other pipeline stages.
- de_pool is never high for two consecutive cycles. Maximum rate is one strobe per 2 input samples.
- frame_done is asserted 1 cycle after the row-end edge is detected. It may coincide with nothing else, since de_pool for that row has already fired.
- Reset or start low mid-row: the next cycle outputs return to reset values and the partial window is discarded. The next de_in=1 sample is treated as column 0 of row 0.
- A row-end and a new de_in=1 on the immediately following cycle are legal. The new sample is column 0 of the next row.

## Configuration
- RELU_EN:
  - Defined: ReLU is applied before pooling. Outputs are non-negative.
  - Undefined: ReLU is bypassed and pooling is signed max over raw sums. Outputs may be negative, with the same width and latency.

## Test plan
- Ramp frame, RELU_EN defined: input pixel (r,c) = r*26+c on all channels → 169 de_pool strobes. Window (0,0) = 27, window (12,12) = 675, with pool_row/pool_col matching. One frame_done.
- Negative inputs, RELU_EN defined: window values {-5, -1, -7, -3} on ch1 → ch1 output 0. Same stimulus with RELU_EN undefined → output -1 (0x1FFFFF).
- Channel independence: window ch0={1,9,2,3}, ch1={8,0,0,0}, ch2={0,0,0,4} → pool_out {9,8,4}.
- Odd geometry, IN_WIDTH=5, IN_HEIGHT=3: full frame → 2 strobes per pooled row and 1 pooled row. The 5th column and 3rd row never produce output. frame_done pulses once.
- RESET low during row 1, column 7, held 1 cycle, then a restarted clean frame → no de_pool from the aborted frame. The first strobe of the new frame has pool_row=0, pool_col=0 and the correct value.
- start dropped mid-frame for 3 cycles then raised with a fresh frame → counters restart. The output matches the reference result for the fresh frame exactly.
